btn_debounce: RTL



---
 rtl/btn_debounce_if.sv | 19 +
 rtl/btn_debounce.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_if.sv
// Button-side signal bundle for btn_debounce: raw pin in, conditioned level/strobes/count out.
interface btn_debounce_if;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, long_pulse, press_count
    );

    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, long_pulse, press_count
    );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, debounce FSM, press/release strobes, wrapping press counter.
// Long-press detector is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 200_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input logic           CLOCK_100Mhz,
    input logic           reset,
    btn_debounce_if.slave btn
);

    localparam int                 DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic               IDLE_PIN = ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    logic             sync1_q, sync2_q;
    logic             s;
    state_e           state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [7:0]       count_q, count_d;

    // Sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge CLOCK_100Mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= btn.btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_100Mhz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.press_count   = count_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_q, long_d;

    // Hold time survives release bounces; only an accepted release rearms the detector.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (release_d) begin
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (state_q == PRESSED && s) begin
            if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else if (!long_done_q) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_100Mhz or posedge reset) begin
        if (reset) begin
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign btn.long_pulse = long_q;
`else
    assign btn.long_pulse = 1'b0;
`endif

endmodule
